// File: rtl/fifo_rd_stream_adapter.sv
// Turns a fixed-latency FIFO read port into a valid/ready stream with a credit-limited RD_LAT+1 entry buffer.
// Optional FIFO_RD_STREAM_STAT_EN adds stat_beats/stat_stall counters.
module fifo_rd_stream_adapter #(
  parameter int DSIZE = 8,
  parameter int RD_LAT = 1,
  localparam int BUF_DEPTH = RD_LAT + 1
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DSIZE-1:0]                 fifo_rdata,
  input  logic                             flush,
  output logic [DSIZE-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count
`ifdef FIFO_RD_STREAM_STAT_EN
  ,
  output logic [31:0]                      stat_beats,
  output logic [31:0]                      stat_stall
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);

  typedef logic [DSIZE-1:0] word_t;

  word_t             mem_q [BUF_DEPTH];
  word_t             mem_d [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     buf_count_q, buf_count_d;
  logic [RD_LAT-1:0] inflight_q, inflight_d;
  logic [CW:0]       inflight_cnt;
  logic [CW:0]       credit_use;
  logic              pop;
  logic              capture;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (buf_count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign buf_count = buf_count_q;
  assign pop       = out_valid && out_ready;
  // Data returning during a flush belongs to discarded reads.
  assign capture   = inflight_q[RD_LAT-1] && !flush;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + (CW+1)'(inflight_q[i]);
    end
    credit_use = (CW+1)'(buf_count_q) + inflight_cnt - (CW+1)'(pop);
    fifo_rd_en = !rst && !fifo_empty && !flush && (credit_use < (CW+1)'(BUF_DEPTH));
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = '0;
    inflight_d[0] = fifo_rd_en;
    for (int i = 1; i < RD_LAT; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end
    if (capture) begin
      mem_d[wr_ptr_q] = fifo_rdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    buf_count_d = buf_count_q + CW'(capture) - CW'(pop);
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      buf_count_d = '0;
      inflight_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      buf_count_q <= '0;
      inflight_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_count_q <= buf_count_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef FIFO_RD_STREAM_STAT_EN
  logic [31:0] stat_beats_q, stat_beats_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_beats_d = stat_beats_q + 32'(pop);
    stat_stall_d = stat_stall_q + 32'(out_valid && !out_ready);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stat_beats_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_beats_q <= stat_beats_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_stall = stat_stall_q;
`endif

`ifndef SYNTHESIS
  // The read credit must keep a capture from landing in a full buffer.
  assert property (@(posedge clock) disable iff (rst)
    !(capture && !pop && buf_count_q == CW'(BUF_DEPTH)));
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: RD_LAT=1 and RD_LAT=2 adapters, each fed by a behavioural fixed-latency FIFO.
module tb_fifo_rd_stream_adapter;

  logic       clock = 1'b0;
  logic       rst;
  always #5 clock = ~clock;

  // RD_LAT=1 instance
  logic       e1, re1, fl1, ov1, or1;
  logic [7:0] rdat1, od1;
  logic [1:0] bc1;
  // RD_LAT=2 instance
  logic       e2, re2, fl2, ov2, or2;
  logic [7:0] rdat2, s2, od2;
  logic [1:0] bc2;
`ifdef FIFO_RD_STREAM_STAT_EN
  logic [31:0] sb1, ss1, sb2, ss2;
`endif

  logic [7:0] fm1 [0:2047];
  logic [7:0] fm2 [0:63];
  int wp1 = 0, rp1 = 0, bad1 = 0;
  int wp2 = 0, rp2 = 0, bad2 = 0;
  int n_chk = 0, n_fail = 0;

  assign e1 = (wp1 == rp1);
  assign e2 = (wp2 == rp2);

  always @(posedge clock) begin
    if (re1) begin
      if (wp1 == rp1) bad1 <= bad1 + 1;
      else begin
        rdat1 <= fm1[rp1];
        rp1   <= rp1 + 1;
      end
    end
  end

  always @(posedge clock) begin
    rdat2 <= s2;
    if (re2) begin
      if (wp2 == rp2) bad2 <= bad2 + 1;
      else begin
        s2  <= fm2[rp2];
        rp2 <= rp2 + 1;
      end
    end
  end

  fifo_rd_stream_adapter #(.DSIZE(8), .RD_LAT(1)) u_dut1 (
    .clock(clock), .rst(rst), .fifo_empty(e1), .fifo_rd_en(re1), .fifo_rdata(rdat1),
    .flush(fl1), .out_data(od1), .out_valid(ov1), .out_ready(or1), .buf_count(bc1)
`ifdef FIFO_RD_STREAM_STAT_EN
    , .stat_beats(sb1), .stat_stall(ss1)
`endif
  );

  fifo_rd_stream_adapter #(.DSIZE(8), .RD_LAT(2)) u_dut2 (
    .clock(clock), .rst(rst), .fifo_empty(e2), .fifo_rd_en(re2), .fifo_rdata(rdat2),
    .flush(fl2), .out_data(od2), .out_valid(ov2), .out_ready(or2), .buf_count(bc2)
`ifdef FIFO_RD_STREAM_STAT_EN
    , .stat_beats(sb2), .stat_stall(ss2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push1(input logic [7:0] d);
    fm1[wp1] = d;
    wp1 = wp1 + 1;
  endtask

  task automatic push2(input logic [7:0] d);
    fm2[wp2] = d;
    wp2 = wp2 + 1;
  endtask

  task automatic step;
    @(negedge clock);
    #1;
  endtask

  initial begin
    int k, base, sent, got, held, start;
    logic hold;
    rst = 1'b1;
    fl1 = 1'b0; or1 = 1'b0; fl2 = 1'b0; or2 = 1'b0;
    rdat1 = '0; rdat2 = '0; s2 = '0;
    #3;
    chk("rst_ov1", 32'(ov1), 0);
    chk("rst_bc1", 32'(bc1), 0);
    chk("rst_od1", 32'(od1), 0);
    chk("rst_re1", 32'(re1), 0);
    chk("rst_ov2", 32'(ov2), 0);
    @(negedge clock);
    rst = 1'b0;
    step();

    // First word, RD_LAT=1
    or1 = 1'b1;
    push1(8'h05);
    #1;
    chk("fw_rd_en", 32'(re1), 1);
    step();
    chk("fw_c1_ov", 32'(ov1), 0);
    step();
    chk("fw_c2_ov", 32'(ov1), 1);
    chk("fw_c2_od", 32'(od1), 32'h05);
    chk("fw_c2_bc", 32'(bc1), 1);
    step();
    chk("fw_c3_bc", 32'(bc1), 0);
    chk("fw_c3_ov", 32'(ov1), 0);

    // Backpressure, RD_LAT=1
    or1 = 1'b0;
    start = rp1;
    for (int i = 0; i < 10; i++) push1(8'(8'h10 + i));
    repeat (6) step();
    chk("bp_reads", 32'(rp1 - start), 2);
    chk("bp_bc", 32'(bc1), 2);
    chk("bp_ov", 32'(ov1), 1);
    chk("bp_od", 32'(od1), 32'h10);
    repeat (3) step();
    chk("bp_od_hold", 32'(od1), 32'h10);
    or1 = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 10; c++) begin
      if (ov1) begin
        chk("bp_beat", 32'(od1), 32'(8'h10 + k));
        k++;
      end
      step();
    end
    chk("bp_count", 32'(k), 10);

    // Random ready and random FIFO writes, RD_LAT=1
    base = wp1; sent = 0; got = 0; hold = 1'b0; held = 0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      if (sent < 1000 && $urandom_range(1, 0) == 1) begin
        push1(8'($urandom));
        sent++;
      end
      or1 = ($urandom_range(1, 0) == 1);
      #1;
      if (hold) begin
        chk("rnd_hold_ov", 32'(ov1), 1);
        chk("rnd_hold_od", 32'(od1), 32'(held));
      end
      if (ov1 && or1) begin
        chk("rnd_beat", 32'(od1), 32'(fm1[base + got]));
        got++;
      end
      hold = ov1 && !or1;
      held = 32'(od1);
      step();
    end
    chk("rnd_count", 32'(got), 1000);

    // Streaming, RD_LAT=2
    or2 = 1'b1;
    for (int i = 0; i < 16; i++) push2(8'(i));
    #1;
    for (int c = 0; c < 20; c++) begin
      chk("st_rd_en", 32'(re2), 32'(c < 16));
      chk("st_ov", 32'(ov2), 32'(c >= 3 && c <= 18));
      if (c >= 3 && c <= 18) chk("st_od", 32'(od2), 32'(c - 3));
      step();
    end

    // Flush with two buffered and one in flight, RD_LAT=2
    or2 = 1'b0;
    for (int i = 0; i < 5; i++) push2(8'(8'h20 + i));
    repeat (4) step();
    chk("fl_pre_bc", 32'(bc2), 2);
    chk("fl_pre_od", 32'(od2), 32'h20);
    fl2 = 1'b1;
    #1;
    chk("fl_rd_en", 32'(re2), 0);
    step();
    fl2 = 1'b0;
    chk("fl_ov", 32'(ov2), 0);
    chk("fl_bc", 32'(bc2), 0);
    or2 = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      if (ov2) begin
        chk("fl_beat", 32'(od2), 32'(8'h23 + k));
        k++;
      end
      step();
    end
    chk("fl_count", 32'(k), 2);

    // Async reset mid-stream, RD_LAT=1
    or1 = 1'b1;
    for (int i = 0; i < 20; i++) push1(8'(8'h40 + i));
    repeat (4) step();
    chk("ar_pre_ov", 32'(ov1), 1);
    chk("ar_pre_re", 32'(re1), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_ov", 32'(ov1), 0);
    chk("ar_re", 32'(re1), 0);
    chk("ar_bc", 32'(bc1), 0);
`ifdef FIFO_RD_STREAM_STAT_EN
    chk("ar_stat_beats", sb1, 0);
`endif
    @(negedge clock);
    rst = 1'b0;
    step();

    chk("rd_while_empty1", 32'(bad1), 0);
    chk("rd_while_empty2", 32'(bad2), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
